// File: rtl/bus_mux_nch_reg.sv
// Registered N-channel bus multiplexer with valid/ready handshake on every
// input channel. The grant comes either from an explicit select or from a
// round-robin search. The winning word is captured in one output register
// together with the index of the channel it came from.
module bus_mux_nch_reg #(
  parameter int WORD_SIZE = 8,
  parameter int N_CH      = 9,
  parameter int SEL_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*WORD_SIZE-1:0] data_in,
  input  logic [N_CH-1:0]           valid_in,
  output logic [N_CH-1:0]           ready_out,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      err_clr,
  output logic [WORD_SIZE-1:0]      mux_out,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready,
  output logic                      sel_err
);

  // One extra bit so that ptr + offset (at most 2*N_CH-1) cannot overflow.
  localparam logic [SEL_W:0]   NCH_L   = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(N_CH - 1);

  logic [WORD_SIZE-1:0] mux_q, mux_d;
  logic                 vld_q, vld_d;
  logic [SEL_W-1:0]     chan_q, chan_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic                 err_q, err_d;

  logic                 load;
  logic                 sel_ok;
  logic                 grant_vld;
  logic [SEL_W-1:0]     grant_idx;
  logic [SEL_W:0]       cand;
  logic [N_CH-1:0]      grant_oh;
  logic [WORD_SIZE-1:0] grant_data;

  // The register can take a word when it is empty or drains this cycle.
  assign load   = !vld_q || out_ready;
  assign sel_ok = ({1'b0, sel} < NCH_L);

  // Grant selection: explicit select, or first valid channel after ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!mode) begin
      if (sel_ok && valid_in[sel]) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end else begin
      for (int k = 1; k <= N_CH; k++) begin
        cand = {1'b0, ptr_q} + k[SEL_W:0];
        if (cand >= NCH_L) cand = cand - NCH_L;
        if (!grant_vld && valid_in[cand[SEL_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[SEL_W-1:0];
        end
      end
    end
  end

  // Decode the grant into a one-hot strobe and pick the granted word.
  always_comb begin
    grant_oh   = '0;
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_vld && (grant_idx == i[SEL_W-1:0])) begin
        grant_oh[i] = 1'b1;
        grant_data  = data_in[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // A channel is accepted only while out of reset and the register loads.
  assign ready_out = (load && rst) ? grant_oh : '0;

  // Next-state for the output register, pointer and sticky error flag.
  always_comb begin
    mux_d  = mux_q;
    vld_d  = vld_q;
    chan_d = chan_q;
    ptr_d  = ptr_q;
    err_d  = err_q;
    if (load) begin
      if (grant_vld) begin
        mux_d  = grant_data;
        chan_d = grant_idx;
        vld_d  = 1'b1;
        if (mode) ptr_d = grant_idx;
      end else begin
        vld_d = 1'b0;
      end
    end
    // A fresh out-of-range select outranks a clear in the same cycle.
    if (!mode && !sel_ok) err_d = 1'b1;
    else if (err_clr)     err_d = 1'b0;
  end

  // State registers; reset empties the output and gives channel 0 priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mux_q  <= '0;
      vld_q  <= 1'b0;
      chan_q <= '0;
      ptr_q  <= PTR_RST;
      err_q  <= 1'b0;
    end else begin
      mux_q  <= mux_d;
      vld_q  <= vld_d;
      chan_q <= chan_d;
      ptr_q  <= ptr_d;
      err_q  <= err_d;
    end
  end

  assign mux_out   = mux_q;
  assign out_valid = vld_q;
  assign out_chan  = chan_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_bus_mux_nch_reg.sv
// Bench for bus_mux_nch_reg: directed scenarios followed by random traffic,
// compared each cycle against a transaction-level reference model.
module tb_bus_mux_nch_reg;
  localparam int W = 8;
  localparam int N = 9;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   valid_in;
  logic [N-1:0]   ready_out;
  logic           mode;
  logic [S-1:0]   sel;
  logic           err_clr;
  logic [W-1:0]   mux_out;
  logic           out_valid;
  logic [S-1:0]   out_chan;
  logic           out_ready;
  logic           sel_err;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [W-1:0] m_out;
  bit           m_vld;
  int           m_chan;
  int           m_ptr;
  bit           m_err;

  always #5 clk = ~clk;

  bus_mux_nch_reg #(.WORD_SIZE(W), .N_CH(N), .SEL_W(S)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .mode(mode), .sel(sel), .err_clr(err_clr),
    .mux_out(mux_out), .out_valid(out_valid), .out_chan(out_chan),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_vld = 0; m_chan = 0; m_err = 0; m_ptr = N - 1;
  endtask

  // Channel that wins arbitration this cycle, or -1 for none.
  function automatic int model_grant();
    int g = -1;
    if (mode == 1'b0) begin
      if (int'(sel) < N && valid_in[sel]) g = int'(sel);
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c = (m_ptr + k) % N;
        if (g < 0 && valid_in[c]) g = c;
      end
    end
    return g;
  endfunction

  task automatic set_data(input logic [W-1:0] base, input bit ramp);
    for (int i = 0; i < N; i++) data_in[i*W +: W] = ramp ? base + W'(i) : base;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".mux_out"},   mux_out,   m_out);
    chk({tag, ".out_valid"}, out_valid, m_vld);
    chk({tag, ".out_chan"},  out_chan,  m_chan);
    chk({tag, ".sel_err"},   sel_err,   m_err);
  endtask

  // One clock: check ready_out before the edge, advance model, check outputs.
  task automatic cyc(input string tag);
    int g;
    bit load;
    logic [N-1:0] er;
    #1;
    g = model_grant();
    load = !m_vld || out_ready;
    er = '0;
    if (load && g >= 0) er[g] = 1'b1;
    chk({tag, ".ready_out"}, ready_out, er);
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        m_out = data_in[g*W +: W]; m_chan = g; m_vld = 1;
        if (mode) m_ptr = g;
      end else begin
        m_vld = 0;
      end
    end
    if (mode == 1'b0 && int'(sel) >= N) m_err = 1;
    else if (err_clr)                   m_err = 0;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst = 0; data_in = '0; valid_in = '0; mode = 0; sel = '0;
    err_clr = 0; out_ready = 0;
    model_reset();
    #12;
    check_outputs("reset");
    chk("reset.ready_out", ready_out, '0);
    @(posedge clk); #1 rst = 1;

    // explicit select of channel 3
    mode = 0; sel = 3; valid_in = 9'h008; out_ready = 1;
    data_in[3*W +: W] = 8'hA5;
    cyc("sel3");
    chk("sel3.word", mux_out, 8'hA5);

    // backpressure holds the word, then drain and refill
    out_ready = 0; data_in[3*W +: W] = 8'h5A;
    cyc("bp_hold");
    chk("bp_hold.word", mux_out, 8'hA5);
    out_ready = 1;
    cyc("bp_drain");
    chk("bp_drain.word", mux_out, 8'h5A);

    // round-robin across all channels from the reset pointer
    mode = 1; valid_in = '1; set_data(8'h10, 1);
    for (int i = 0; i <= N; i++) begin
      cyc("rr");
      chk("rr.seq", out_chan, i % N);
    end

    // park pointer on 7, then skip and wrap between ch0 and ch2
    valid_in = 9'h080;
    cyc("rr_park");
    valid_in = 9'h005;
    cyc("rr_wrap0"); chk("rr_wrap0.chan", out_chan, 0);
    cyc("rr_wrap2"); chk("rr_wrap2.chan", out_chan, 2);
    cyc("rr_wrap0b"); chk("rr_wrap0b.chan", out_chan, 0);

    // out-of-range select sets the sticky error
    mode = 0; sel = 12; valid_in = '1;
    cyc("oor");
    chk("oor.err", sel_err, 1);
    chk("oor.vld", out_valid, 0);
    err_clr = 1;
    cyc("oor_clr_lose");
    chk("oor_clr_lose.err", sel_err, 1);
    sel = 2;
    cyc("oor_clr");
    chk("oor_clr.err", sel_err, 0);
    err_clr = 0;

    // asynchronous reset while a word is held
    mode = 1; valid_in = '1; out_ready = 0; set_data(8'h30, 1);
    cyc("pre_rst");
    #2 rst = 0;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst.ready_out", ready_out, '0);
    @(negedge clk) rst = 1;
    out_ready = 1;
    cyc("post_rst");
    chk("post_rst.chan", out_chan, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      mode      = ($urandom_range(0, 3) != 0);
      sel       = S'($urandom_range(0, 15));
      valid_in  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) data_in[i*W +: W] = W'($urandom);
      cyc("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_mux_nch_reg.md
Name: bus_mux_nch_reg

Overview:
- Registered N-channel bus multiplexer with per-channel valid/ready handshake.
- Two selection modes: explicit select, or round-robin arbitration among channels with valid data.
- One output register stage.
- Replaces the fixed 9-channel combinational mux where datapath sources (registers, ALU, memory, immediates) share one bus and need flow control, arbitration and source tagging.

Parameters:
- WORD_SIZE, 8, data width per channel.
- N_CH, 9, number of input channels, 2..16.
- SEL_W, 4, select/channel-index width; must satisfy 2^SEL_W >= N_CH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  N_CH*WORD_SIZE  packed channel data; channel i occupies bits [i*WORD_SIZE +: WORD_SIZE].
- valid_in  in  N_CH  channel i presents data.
- ready_out  out  N_CH  channel i is accepted this cycle.
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SEL_W  channel index used when mode=0.
- err_clr  in  1  clears sel_err.
- mux_out  out  WORD_SIZE  registered output data.
- out_valid  out  1  mux_out holds unconsumed data.
- out_chan  out  SEL_W  channel index that produced mux_out.
- out_ready  in  1  downstream accepts mux_out.
- sel_err  out  1  sticky flag: out-of-range sel seen in mode 0.

Behaviour:
- Reset (rst=0, asynchronous): mux_out=0, out_valid=0, out_chan=0, sel_err=0, round-robin pointer ptr=N_CH-1, so channel 0 has first priority. Reset asserted mid-transfer discards the held word. ready_out is all-zero while rst=0.
- Load enable: load = !out_valid || out_ready. The output register accepts new data when it is empty or is being drained in the same cycle.
- Grant, combinational, at most one channel:
  - mode 0: grant = sel when sel < N_CH and valid_in[sel]=1; otherwise no grant.
  - mode 1: search channels ptr+1, ptr+2, … wrapping modulo N_CH, ending at ptr. Grant the first channel with valid_in=1. If none is valid, no grant.
- ready_out[i] = load && (grant == i). ready_out never depends on valid_in of other channels in mode 0.
- Transfer on channel g (load && grant present), at the clock edge: mux_out<=data_in[g], out_chan<=g, out_valid<=1. In mode 1 only, ptr<=g.
- Load with no grant: out_valid<=0. mux_out and out_chan hold their last values.
- No load (out_valid=1, out_ready=0): all outputs hold; ready_out=0.
- Latency: 1 cycle from the accepted input to out_valid. Throughput is one word per cycle with out_ready held high. No bubble when draining and refilling in the same cycle.
- Out-of-range select (mode=0, sel >= N_CH): no grant, no transfer. sel_err<=1 at the next edge regardless of valid_in. The output never goes undefined.
- sel_err: sticky until err_clr=1 at a clock edge.
  - If err_clr and a new out-of-range condition occur in the same cycle, the set wins: sel_err stays 1.
  - sel_err does not stall the datapath.
- Mode change: takes effect at the next grant evaluation. ptr is retained across mode 0 periods. A word already held in mux_out is unaffected.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,…,N_CH-1,0…. Every requesting channel is served within N_CH transfers.
- Data on non-granted channels is ignored. A channel must hold data stable while valid_in=1 and ready_out=0.

Test Plan:
- Reset then explicit select: rst low→high; mode=0, sel=3, valid_in=9'h008, data ch3=8'hA5, out_ready=1 → ready_out=9'h008 in that cycle; next cycle mux_out=8'hA5, out_chan=3, out_valid=1.
- Backpressure: out_valid=1 with 8'hA5, out_ready=0, ch3 presents 8'h5A → ready_out=0, mux_out holds 8'hA5. Raise out_ready → same cycle ready_out[3]=1; next cycle mux_out=8'h5A.
- Round-robin: mode=1, all nine channels valid, data ch i=8'h10+i, out_ready=1 → out_chan sequence 0..8,0 on consecutive cycles, with mux_out=8'h10..8'h18.
- Round-robin skip/wrap: ptr=7, valid_in=9'h005 (ch0, ch2) → grant ch0, then ch2, then ch0.
- Out-of-range select: mode=0, sel=12, valid_in=all ones → ready_out=0, sel_err=1 next cycle. After out_ready drains the held word, out_valid=0. err_clr=1 with sel=12 still applied → sel_err stays 1. With sel=2 and err_clr=1 → sel_err=0.
- Async reset mid-stream: assert rst=0 between clock edges while out_valid=1 → mux_out=0, out_valid=0 immediately. After release, the first round-robin grant goes to ch0.
